// File: rtl/ir_decode_sequencer.sv
// Instruction fetch/decode sequencer: one-hot timing generator, IR load and field decode.
// Optional macro IR_RRIO_DECODE_EN adds registered rr_exec/io_exec qualifiers.
module ir_decode_sequencer #(
    parameter  int WORD_W = 16,
    parameter  int OP_W   = 3,
    parameter  int SC_W   = 4,
    localparam int ADDR_W = WORD_W - 1 - OP_W,
    localparam int NT     = 2 ** SC_W,
    localparam int ND     = 2 ** OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              mem_valid,
    input  logic              sc_clr,
    input  logic              halt,
    output logic              mem_req,
    output logic [NT-1:0]     t,
    output logic [WORD_W-1:0] ir,
    output logic [ADDR_W-1:0] ar,
    output logic              i_bit,
    output logic [ND-1:0]     d,
`ifdef IR_RRIO_DECODE_EN
    output logic              rr_exec,
    output logic              io_exec,
`endif
    output logic              decode_valid,
    output logic              sc_err
);

    localparam logic [SC_W-1:0] SC_T0  = SC_W'(0);
    localparam logic [SC_W-1:0] SC_T1  = SC_W'(1);
    localparam logic [SC_W-1:0] SC_T2  = SC_W'(2);
    localparam logic [SC_W-1:0] SC_T3  = SC_W'(3);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(NT - 1);

    logic [SC_W-1:0]   sc_q,  sc_d;
    logic [WORD_W-1:0] ir_q,  ir_d;
    logic [ADDR_W-1:0] ar_q,  ar_d;
    logic              i_q,   i_d;
    logic [ND-1:0]     d_q,   d_d;
    logic              dv_q,  dv_d;
    logic              err_q, err_d;
`ifdef IR_RRIO_DECODE_EN
    logic              rr_q,  rr_d;
    logic              io_q,  io_d;
`endif

    logic [OP_W-1:0] opcode;
    assign opcode = ir_q[WORD_W-2 -: OP_W];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        sc_d  = sc_q;
        ir_d  = ir_q;
        ar_d  = ar_q;
        i_d   = i_q;
        d_d   = d_q;
        dv_d  = dv_q;
        err_d = err_q;
`ifdef IR_RRIO_DECODE_EN
        rr_d  = rr_q;
        io_d  = io_q;
`endif
        if (sc_q == SC_T0) begin
            if (!halt) sc_d = SC_T1;
        end else if (sc_q == SC_T1) begin
            if (mem_valid && !halt) begin
                ir_d = mem_data;
                sc_d = SC_T2;
            end
        end else if (sc_q == SC_T2) begin
            // Decode straight from the freshly loaded IR so fields never lag the opcode.
            if (!halt) begin
                ar_d = ir_q[ADDR_W-1:0];
                i_d  = ir_q[WORD_W-1];
                d_d  = {{(ND-1){1'b0}}, 1'b1} << opcode;
                dv_d = 1'b1;
                sc_d = SC_T3;
`ifdef IR_RRIO_DECODE_EN
                rr_d = d_d[ND-1] & ~i_d;
                io_d = d_d[ND-1] &  i_d;
`endif
            end
        end else if (sc_clr) begin
            // sc_clr outranks halt; decoded fields stay for inspection.
            sc_d = SC_T0;
            dv_d = 1'b0;
`ifdef IR_RRIO_DECODE_EN
            rr_d = 1'b0;
            io_d = 1'b0;
`endif
        end else if (sc_q == SC_MAX) begin
            err_d = 1'b1;
        end else if (!halt) begin
            sc_d = sc_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (!rst_n) begin
            sc_q  <= SC_T0;
            ir_q  <= '0;
            ar_q  <= '0;
            i_q   <= 1'b0;
            d_q   <= '0;
            dv_q  <= 1'b0;
            err_q <= 1'b0;
`ifdef IR_RRIO_DECODE_EN
            rr_q  <= 1'b0;
            io_q  <= 1'b0;
`endif
        end else begin
            sc_q  <= sc_d;
            ir_q  <= ir_d;
            ar_q  <= ar_d;
            i_q   <= i_d;
            d_q   <= d_d;
            dv_q  <= dv_d;
            err_q <= err_d;
`ifdef IR_RRIO_DECODE_EN
            rr_q  <= rr_d;
            io_q  <= io_d;
`endif
        end
    end

    assign mem_req      = (sc_q == SC_T1);
    assign t            = {{(NT-1){1'b0}}, 1'b1} << sc_q;
    assign ir           = ir_q;
    assign ar           = ar_q;
    assign i_bit        = i_q;
    assign d            = d_q;
    assign decode_valid = dv_q;
    assign sc_err       = err_q;
`ifdef IR_RRIO_DECODE_EN
    assign rr_exec      = rr_q;
    assign io_exec      = io_q;
`endif

endmodule

// File: doc/ir_decode_sequencer.md
IR_DECODE_SEQUENCER -- requirements
Module: ir_decode_sequencer

Interface
REQ-001 SHALL have parameter WORD_W, default 16, instruction word width.
REQ-002 SHALL have parameter OP_W, default 3, opcode field width; ADDR_W = WORD_W-1-OP_W is derived, not overridable.
REQ-003 SHALL have parameter SC_W, default 4, sequence counter width; timing vector width NT = 2**SC_W.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port mem_data  input  WORD_W  instruction word from memory.
REQ-007 SHALL have port mem_valid  input  1  mem_data valid this cycle.
REQ-008 SHALL have port sc_clr  input  1  end of instruction, return sequencer to T0.
REQ-009 SHALL have port halt  input  1  freeze sequence counter.
REQ-010 SHALL have port mem_req  output  1  fetch request, high while in T1 awaiting mem_valid.
REQ-011 SHALL have port t  output  NT  one-hot timing signals T0..T(NT-1).
REQ-012 SHALL have port ir  output  WORD_W  instruction register.
REQ-013 SHALL have port ar  output  ADDR_W  address field, ir[ADDR_W-1:0].
REQ-014 SHALL have port i_bit  output  1  indirect bit, ir[WORD_W-1].
REQ-015 SHALL have port d  output  2**OP_W  one-hot decoded opcode, ir[WORD_W-2 -: OP_W].
REQ-016 SHALL have port decode_valid  output  1  ar/i_bit/d valid for current instruction.
REQ-017 SHALL have port sc_err  output  1  sticky sequence counter overflow flag.

Function
REQ-018 SHALL keep sequence counter sc; t SHALL equal one-hot of sc at all times.
REQ-019 In T0, SHALL advance sc to 1 on next edge unless halt is high.
REQ-020 In T1, mem_req SHALL be 1; sc SHALL hold at 1 while mem_valid is 0 (stall, unlimited).
REQ-021 In T1 with mem_valid=1 and halt=0, SHALL load ir <= mem_data and sc <= 2 on the same edge.
REQ-022 In T2, SHALL latch ar, i_bit and d from the current ir (no stale-opcode lag), set decode_valid=1, sc <= 3, all on one edge.
REQ-023 Fetch-to-decode latency SHALL be exactly 2 edges from the mem_valid edge to decode_valid=1, with halt low.
REQ-024 In sc>=3, sc SHALL increment each edge while halt=0 and sc_clr=0.
REQ-025 sc_clr SHALL be honoured only when sc>=3: next edge sc <= 0, decode_valid <= 0; ir/ar/i_bit/d hold.
REQ-026 sc_clr while sc<3 SHALL be ignored.
REQ-027 sc_clr and halt both high SHALL give sc_clr priority.
REQ-028 halt=1 SHALL freeze sc and block ir load and decode latch; mem_req follows sc.
REQ-029 At sc = NT-1 without sc_clr, sc SHALL hold (no wrap) and sc_err SHALL set and remain 1 until reset.
REQ-030 d SHALL be all-zero until the first decode, then exactly one bit set.

Reset
REQ-031 rst_n=0 at an edge SHALL force sc=0 (t=1), ir=0, ar=0, i_bit=0, d=0, decode_valid=0, mem_req=0, sc_err=0, overriding all other inputs, including mid-instruction.
REQ-032 After rst_n returns high, the first edge SHALL move T0 to T1.

Configuration
REQ-033 Macro IR_RRIO_DECODE_EN defined SHALL add outputs rr_exec (d[MSB] & ~i_bit & decode_valid) and io_exec (d[MSB] & i_bit & decode_valid), both registered with d, reset 0.
REQ-034 Without IR_RRIO_DECODE_EN those ports and logic SHALL be absent; all other behaviour identical.

Verification (WORD_W=16, OP_W=3, SC_W=4)
REQ-035 Reset release, mem_data=16'h2ABC with mem_valid in T1 -> ir=16'h2ABC, after 1 further edge: ar=12'hABC, i_bit=0, d=8'h04, decode_valid=1, t=16'h0008.
REQ-036 mem_valid held low 5 cycles in T1 -> mem_req=1, t=16'h0002 throughout; load occurs on the first mem_valid edge.
REQ-037 mem_data=16'hF123, sc_clr at T4 -> d=8'h80, i_bit=1, io_exec=1 (macro on); next edge t=16'h0001, decode_valid=0.
REQ-038 sc_clr asserted in T2 and halt asserted in T5 with sc_clr -> sc_clr ignored in T2; T5 clears to T0.
REQ-039 No sc_clr after decode -> sc reaches 15, holds, sc_err=1 sticky; rst_n low one edge -> all outputs at reset values.
